// File: rtl/fifo_rd_scheduler.sv
// Weighted round-robin read scheduler: grants one non-empty FIFO queue at a time,
// strobing rd up to the queue's quota, and tags each read for the downstream consumer.
module fifo_rd_scheduler #(
   parameter int NQ = 4,
   parameter int QW = 4,
   localparam int SW = $clog2(NQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NQ-1:0]      emp,
   input  logic [NQ*QW-1:0]   quota,
   input  logic               out_rdy,
   output logic [NQ-1:0]      rd,
   output logic [SW-1:0]      tag,
   output logic               tag_vld,
   output logic               busy,
   output logic [SW-1:0]      cur_q
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t          state_reg, state_next;
   logic [SW-1:0]   cur_reg, cur_next;
   logic [SW-1:0]   ptr_reg, ptr_next;
   logic [QW-1:0]   credit_reg, credit_next;
   logic [SW-1:0]   tag_reg;
   logic            tag_vld_reg;

   logic [QW-1:0]   q_arr [NQ];
   logic [NQ-1:0]   elig;
   logic [SW-1:0]   start_idx;
   logic [SW-1:0]   winner;
   logic            found;
   logic            issue;
   logic            release_q;

   genvar gi;
   generate
      for (gi = 0; gi < NQ; gi++) begin : g_elig
         assign q_arr[gi] = quota[gi*QW +: QW];
         assign elig[gi]  = ~emp[gi] & (|q_arr[gi]);
      end
   endgenerate

   function automatic logic [SW-1:0] inc_idx(input logic [SW-1:0] i);
      return (i == SW'(NQ-1)) ? '0 : i + 1'b1;
   endfunction

   // In SERVE the search only matters on release, where it must start after cur.
   assign start_idx = (state_reg == SERVE) ? inc_idx(cur_reg) : ptr_reg;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      // Walk backwards so the last hit is the first eligible index from start_idx.
      for (int k = NQ - 1; k >= 0; k--) begin
         if (elig[(int'(start_idx) + k) % NQ]) begin
            found  = 1'b1;
            winner = SW'((int'(start_idx) + k) % NQ);
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      cur_next    = cur_reg;
      credit_next = credit_reg;
      ptr_next    = ptr_reg;
      issue       = 1'b0;
      release_q   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (en && found) begin
               state_next  = SERVE;
               cur_next    = winner;
               credit_next = q_arr[winner];
            end
         end
         SERVE: begin
            issue     = en & out_rdy & ~emp[cur_reg];
            release_q = (issue && credit_reg == QW'(1)) || emp[cur_reg] || !en;
            if (issue)
               credit_next = credit_reg - 1'b1;
            if (release_q) begin
               ptr_next = inc_idx(cur_reg);
               if (!en || !found) begin
                  state_next = IDLE;
               end else begin
                  cur_next    = winner;
                  credit_next = q_arr[winner];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rd = '0;
      if (issue)
         rd[cur_reg] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         cur_reg     <= '0;
         credit_reg  <= '0;
         ptr_reg     <= '0;
         tag_reg     <= '0;
         tag_vld_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cur_reg     <= cur_next;
         credit_reg  <= credit_next;
         ptr_reg     <= ptr_next;
         tag_vld_reg <= issue;
         if (issue)
            tag_reg <= cur_reg;
      end
   end

   assign tag     = tag_reg;
   assign tag_vld = tag_vld_reg;
   assign busy    = (state_reg == SERVE);
   assign cur_q   = cur_reg;

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Directed bench for fifo_rd_scheduler; each FIFO is modelled as a word counter
// whose empty flag drops one cycle after the read that drains it.
module tb_fifo_rd_scheduler;

   localparam int NQ = 4;
   localparam int QW = 4;

   logic          clk;
   logic          rst;
   logic          en;
   logic [NQ-1:0] emp;
   logic [15:0]   quota;
   logic          out_rdy;
   logic [NQ-1:0] rd;
   logic [1:0]    tag;
   logic          tag_vld;
   logic          busy;
   logic [1:0]    cur_q;

   int            cnt [NQ];
   int            checks;
   int            failures;

   logic [3:0]    rd_obs;
   logic          tv_obs;
   logic          busy_obs;
   logic [1:0]    tag_obs;
   logic [1:0]    curq_obs;

   fifo_rd_scheduler #(.NQ(NQ), .QW(QW)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .emp     (emp),
      .quota   (quota),
      .out_rdy (out_rdy),
      .rd      (rd),
      .tag     (tag),
      .tag_vld (tag_vld),
      .busy    (busy),
      .cur_q   (cur_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      for (int i = 0; i < NQ; i++)
         emp[i] = (cnt[i] == 0);
   end

   // One cycle: observe at the falling edge, then apply the reads to the counters after the rising edge.
   task automatic tick();
      @(negedge clk);
      rd_obs   = rd;
      tv_obs   = tag_vld;
      tag_obs  = tag;
      busy_obs = busy;
      curq_obs = cur_q;
      @(posedge clk);
      #1;
      for (int i = 0; i < NQ; i++)
         if (rd_obs[i] && cnt[i] > 0) cnt[i] = cnt[i] - 1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      en      = 1'b0;
      out_rdy = 1'b1;
      quota   = 16'h0000;
      for (int i = 0; i < NQ; i++) cnt[i] = 0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      en      = 1'b1;
      out_rdy = 1'b1;
      quota   = 16'h2222;
      for (int i = 0; i < NQ; i++) cnt[i] = 100;
      tick();
      tick();
      checks++;
      if (rd_obs !== 4'b0000 || tv_obs !== 1'b0 || busy_obs !== 1'b0 ||
          curq_obs !== 2'd0 || tag_obs !== 2'd0) begin
         failures++;
         $display("FAIL reset_state: rd=%b tag_vld=%b busy=%b cur_q=%0d tag=%0d required all zero",
                  rd_obs, tv_obs, busy_obs, curq_obs, tag_obs);
      end
      $display("reset: rd=%b tag_vld=%b busy=%b cur_q=%0d", rd_obs, tv_obs, busy_obs, curq_obs);
      rst = 1'b0;
   endtask

   task automatic test_idle_empty();
      do_reset();
      quota = 16'h2222;
      en    = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if (rd_obs !== 4'b0000 || tv_obs !== 1'b0 || busy_obs !== 1'b0) begin
            failures++;
            $display("FAIL idle_empty c%0d: rd=%b tag_vld=%b busy=%b required 0/0/0",
                     c, rd_obs, tv_obs, busy_obs);
         end
      end
      $display("idle_empty: 20 cycles observed");
   endtask

   task automatic test_rotation();
      logic [3:0] exp_rd  [11] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd1};
      logic [1:0] exp_tag [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      do_reset();
      quota   = 16'h2222;
      out_rdy = 1'b1;
      for (int i = 0; i < NQ; i++) cnt[i] = 100;
      en = 1'b1;
      for (int c = 0; c < 11; c++) begin
         tick();
         checks++;
         if (rd_obs !== exp_rd[c]) begin
            failures++;
            $display("FAIL rotation_rd c%0d: rd=%b required %b", c, rd_obs, exp_rd[c]);
         end
         checks++;
         if (c >= 2) begin
            if (tv_obs !== 1'b1 || tag_obs !== exp_tag[c]) begin
               failures++;
               $display("FAIL rotation_tag c%0d: tag_vld=%b tag=%0d required 1/%0d",
                        c, tv_obs, tag_obs, exp_tag[c]);
            end
         end else if (tv_obs !== 1'b0) begin
            failures++;
            $display("FAIL rotation_tag c%0d: tag_vld=%b required 0", c, tv_obs);
         end
         $display("rotation c%0d: rd=%b tag_vld=%b tag=%0d", c, rd_obs, tv_obs, tag_obs);
      end
   endtask

   task automatic test_quota_zero();
      logic [3:0] exp_rd [8] = '{4'd0, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
      do_reset();
      quota  = 16'h1301;
      cnt[1] = 5;
      cnt[2] = 3;
      en     = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (rd_obs !== exp_rd[c]) begin
            failures++;
            $display("FAIL quota_zero_rd c%0d: rd=%b required %b", c, rd_obs, exp_rd[c]);
         end
         $display("quota_zero c%0d: rd=%b busy=%b", c, rd_obs, busy_obs);
      end
      checks++;
      if (busy_obs !== 1'b0 || cnt[1] != 5 || cnt[2] != 0) begin
         failures++;
         $display("FAIL quota_zero_end: busy=%b q1_words=%0d q2_words=%0d required 0/5/0",
                  busy_obs, cnt[1], cnt[2]);
      end
   endtask

   task automatic test_stall();
      logic [3:0] exp_rd [9] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
      logic       exp_tv [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      quota  = 16'h4444;
      cnt[0] = 10;
      cnt[1] = 10;
      en     = 1'b1;
      for (int c = 0; c < 9; c++) begin
         out_rdy = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
         tick();
         checks++;
         if (rd_obs !== exp_rd[c] || tv_obs !== exp_tv[c]) begin
            failures++;
            $display("FAIL stall c%0d: rd=%b tag_vld=%b required %b/%b",
                     c, rd_obs, tv_obs, exp_rd[c], exp_tv[c]);
         end
         if (c >= 1 && c <= 7) begin
            checks++;
            if (curq_obs !== 2'd0 || busy_obs !== 1'b1) begin
               failures++;
               $display("FAIL stall_hold c%0d: cur_q=%0d busy=%b required 0/1", c, curq_obs, busy_obs);
            end
         end
         $display("stall c%0d: out_rdy=%b rd=%b cur_q=%0d", c, out_rdy, rd_obs, curq_obs);
      end
   endtask

   task automatic test_empty_wrap();
      logic [3:0] exp_rd   [9] = '{4'd0, 4'd8, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
      logic [1:0] exp_curq [9] = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      int         q0_reads;
      do_reset();
      quota    = 16'h5005;
      cnt[3]   = 1;
      en       = 1'b1;
      q0_reads = 0;
      for (int c = 0; c < 9; c++) begin
         tick();
         if (c == 0) cnt[0] = 5;
         if (rd_obs[0]) q0_reads++;
         checks++;
         if (rd_obs !== exp_rd[c]) begin
            failures++;
            $display("FAIL empty_wrap_rd c%0d: rd=%b required %b", c, rd_obs, exp_rd[c]);
         end
         if (c >= 1) begin
            checks++;
            if (curq_obs !== exp_curq[c]) begin
               failures++;
               $display("FAIL empty_wrap_cur c%0d: cur_q=%0d required %0d", c, curq_obs, exp_curq[c]);
            end
         end
         $display("empty_wrap c%0d: rd=%b cur_q=%0d", c, rd_obs, curq_obs);
      end
      tick();
      checks++;
      if (q0_reads != 5 || busy_obs !== 1'b0) begin
         failures++;
         $display("FAIL empty_wrap_end: q0_reads=%0d busy=%b required 5/0", q0_reads, busy_obs);
      end
   endtask

   task automatic test_reset_mid_serve();
      do_reset();
      quota   = 16'h2222;
      out_rdy = 1'b1;
      for (int i = 0; i < NQ; i++) cnt[i] = 100;
      en = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      checks++;
      if (rd_obs !== 4'b0010 || busy_obs !== 1'b1) begin
         failures++;
         $display("FAIL mid_serve_pre: rd=%b busy=%b required 0010/1", rd_obs, busy_obs);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (rd !== 4'b0000 || tag_vld !== 1'b0 || busy !== 1'b0 || cur_q !== 2'd0) begin
         failures++;
         $display("FAIL mid_serve_rst: rd=%b tag_vld=%b busy=%b cur_q=%0d required 0/0/0/0",
                  rd, tag_vld, busy, cur_q);
      end
      $display("mid_serve_rst: rd=%b tag_vld=%b busy=%b", rd, tag_vld, busy);
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (rd_obs !== 4'b0000) begin
         failures++;
         $display("FAIL mid_serve_regrant_idle: rd=%b required 0000", rd_obs);
      end
      tick();
      checks++;
      if (rd_obs !== 4'b0001 || curq_obs !== 2'd0) begin
         failures++;
         $display("FAIL mid_serve_regrant: rd=%b cur_q=%0d required 0001/0", rd_obs, curq_obs);
      end
      $display("mid_serve_regrant: rd=%b cur_q=%0d", rd_obs, curq_obs);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      en       = 1'b0;
      out_rdy  = 1'b1;
      quota    = 16'h0000;
      for (int i = 0; i < NQ; i++) cnt[i] = 0;
      test_reset();
      test_idle_empty();
      test_rotation();
      test_quota_zero();
      test_stall();
      test_empty_wrap();
      test_reset_mid_serve();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
